// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_stage_pkg;

   localparam int unsigned XLEN      = 32;
   localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
   localparam logic [XLEN-1:0] PC_STEP   = 32'h0000_0004;

   typedef enum logic [1:0] {
      ST_ISSUE = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Bundles the hazard/redirect controls, the imem port and the IF/ID outputs.
interface fetch_stage_if;
   import fetch_stage_pkg::*;

   logic            pc_write;
   logic            if_id_write;
   logic            branch_taken;
   logic [XLEN-1:0] branch_target;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;
   logic [XLEN-1:0] if_pc;
   logic [XLEN-1:0] if_instr;
   logic            if_valid;

   modport master (
      input  pc_write, if_id_write, branch_taken, branch_target,
      input  imem_rvalid, imem_rdata,
      output imem_req, imem_addr,
      output if_pc, if_instr, if_valid
   );

   modport slave (
      output pc_write, if_id_write, branch_taken, branch_target,
      output imem_rvalid, imem_rdata,
      input  imem_req, imem_addr,
      input  if_pc, if_instr, if_valid
   );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise hold.
module fetch_stage_if_id_reg
   import fetch_stage_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] instr_i,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] instr_o,
   output logic            valid_o
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] instr_q;
   logic            valid_q;

   // Register update: bubble on flush, capture on load, else keep.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= '0;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
      end else if (flush_i) begin
         pc_q    <= '0;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
      end else if (load_i) begin
         pc_q    <= pc_i;
         instr_q <= instr_i;
         valid_q <= 1'b1;
      end
   end

   assign pc_o    = pc_q;
   assign instr_o = instr_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, single-outstanding imem FSM, one-entry hold buffer.
module fetch_stage
   import fetch_stage_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   fetch_stage_if.master bus
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] buf_pc_q, buf_pc_d;
   logic [XLEN-1:0] buf_instr_q, buf_instr_d;
   logic            kill_q, kill_d;
   logic            adv;
   logic            ifid_load;
   logic            ifid_flush;
   logic [XLEN-1:0] ifid_pc;
   logic [XLEN-1:0] ifid_instr;
   logic [XLEN-1:0] pc_next_seq;

   // A partial stall from the hazard unit is treated as a full stall.
   assign adv         = bus.pc_write & bus.if_id_write;
   assign pc_next_seq = pc_q + PC_STEP;

   // State, PC, kill flag and hold buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_ISSUE;
         pc_q        <= RESET_PC;
         kill_q      <= 1'b0;
         buf_pc_q    <= '0;
         buf_instr_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         kill_q      <= kill_d;
         buf_pc_q    <= buf_pc_d;
         buf_instr_q <= buf_instr_d;
      end
   end

   // Next state and IF/ID control; a redirect overrides everything.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      kill_d      = kill_q;
      buf_pc_d    = buf_pc_q;
      buf_instr_d = buf_instr_q;
      ifid_load   = 1'b0;
      ifid_flush  = 1'b0;
      ifid_pc     = pc_q;
      ifid_instr  = bus.imem_rdata;

      if (bus.branch_taken) begin
         ifid_flush  = 1'b1;
         pc_d        = bus.branch_target;
         buf_pc_d    = '0;
         buf_instr_d = '0;
         unique case (state_q)
            ST_ISSUE: begin
               // The request issued this cycle is for the old path.
               state_d = ST_WAIT;
               kill_d  = 1'b1;
            end
            ST_WAIT: begin
               if (bus.imem_rvalid) begin
                  state_d = ST_ISSUE;
                  kill_d  = 1'b0;
               end else begin
                  kill_d  = 1'b1;
               end
            end
            default: begin
               state_d = ST_ISSUE;
               kill_d  = 1'b0;
            end
         endcase
      end else begin
         unique case (state_q)
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
               if (bus.imem_rvalid) begin
                  if (kill_q) begin
                     kill_d     = 1'b0;
                     state_d    = ST_ISSUE;
                     ifid_flush = bus.if_id_write;
                  end else if (adv) begin
                     ifid_load = 1'b1;
                     pc_d      = pc_next_seq;
                     state_d   = ST_ISSUE;
                  end else begin
                     buf_pc_d    = pc_q;
                     buf_instr_d = bus.imem_rdata;
                     state_d     = ST_HOLD;
                  end
               end else begin
                  ifid_flush = bus.if_id_write;
               end
            end
            ST_HOLD: begin
               ifid_pc    = buf_pc_q;
               ifid_instr = buf_instr_q;
               if (adv) begin
                  ifid_load = 1'b1;
                  pc_d      = pc_next_seq;
                  state_d   = ST_ISSUE;
               end
            end
            default: state_d = ST_ISSUE;
         endcase
      end
   end

   // Request is suppressed while reset is held even though state reads ISSUE.
   assign bus.imem_req  = (state_q == ST_ISSUE) & ~rst;
   assign bus.imem_addr = pc_q;

   fetch_stage_if_id_reg u_if_id_reg (
      .clk     (clk),
      .rst     (rst),
      .load_i  (ifid_load),
      .flush_i (ifid_flush),
      .pc_i    (ifid_pc),
      .instr_i (ifid_instr),
      .pc_o    (bus.if_pc),
      .instr_o (bus.if_instr),
      .valid_o (bus.if_valid)
   );

endmodule
